uart_rx_16x: RTL and testbench

- 8N1 UART receiver with 16x oversampling, majority-vote bit sampling, framing-error detection and a one-entry valid/ready output holding register.
- Sits directly upstream of the ASCII-to-hex digit stage, which consumes its bytes.
- Replaces the single-pulse done interface with a backpressure-safe handshake and overrun reporting.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_os_tick.sv | 29 ++
 rtl/uart_rx_16x.sv | 148 ++++++++++++++
 tb/tb_uart_rx_16x.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversample constants and helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam int unsigned OS_RATE = 16;

  // Sub-bit positions of the three votes taken around the bit centre.
  localparam logic [3:0] SC_SAMPLE_A = 4'd7;
  localparam logic [3:0] SC_SAMPLE_B = 4'd8;
  localparam logic [3:0] SC_SAMPLE_C = 4'd9;
  localparam logic [3:0] SC_LAST     = 4'(OS_RATE - 1);

  // Clocks per oversample tick, never below one.
  function automatic int unsigned os_div(input int unsigned clk_freq, input int unsigned baud);
    int unsigned div;
    div = clk_freq / (baud * OS_RATE);
    return (div == 0) ? 1 : div;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, synchronously clearable so the
// tick phase can be re-aligned to an external event.
module uart_os_tick #(
  parameter int unsigned DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = ~clr & (cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote, framing-error detection and a
// one-entry valid/ready holding register with overrun reporting.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned OS_DIV    = os_div(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  logic       rx_meta_q, rx_s_q;
  logic [1:0] sync_fill_q;

  rx_state_e  state_q;
  logic       armed_q;
  logic [3:0] sc_q;
  logic [2:0] bit_idx_q;
  logic [1:0] samp_q;
  logic [7:0] shift_q;

  logic [7:0] data_q;
  logic       valid_q, frame_err_q, overrun_q;

  logic tick, start_det, counting, at_vote, maj, stop_ok, stop_bad;

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      sync_fill_q <= '0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
    end
  end

  // A start is only accepted once the line has been seen high through a flushed synchronizer,
  // so a line that is low out of reset (or mid-frame) cannot fake a start bit.
  assign start_det = (state_q == StIdle) && armed_q && !rx_s_q;
  assign counting  = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign at_vote   = tick && (sc_q == SC_SAMPLE_C);
  assign maj       = maj3(samp_q[1], samp_q[0], rx_s_q);
  assign stop_ok   = (state_q == StStop) && at_vote && maj;
  assign stop_bad  = (state_q == StStop) && at_vote && !maj;

  uart_os_tick #(
    .DIV (OS_DIV)
  ) u_os_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      sc_q        <= '0;
      bit_idx_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;

      if (stop_ok) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      if (tick && counting) begin
        sc_q <= sc_q + 4'd1;
        if (sc_q == SC_SAMPLE_A) samp_q[1] <= rx_s_q;
        if (sc_q == SC_SAMPLE_B) samp_q[0] <= rx_s_q;
      end

      unique case (state_q)
        StIdle: begin
          if (start_det) begin
            state_q <= StStart;
            sc_q    <= '0;
            armed_q <= 1'b0;
          end else if (rx_s_q && sync_fill_q[1]) begin
            armed_q <= 1'b1;
          end
        end
        StStart: begin
          if (at_vote && maj) begin
            state_q <= StIdle;
            armed_q <= 1'b1;
          end else if (tick && (sc_q == SC_LAST)) begin
            state_q   <= StData;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (at_vote) shift_q <= {maj, shift_q[7:1]};
          if (tick && (sc_q == SC_LAST)) begin
            if (bit_idx_q == 3'd7) state_q <= StStop;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        StStop: begin
          // Leaving mid-stop-bit lets a shortened stop bit be followed straight by a new start.
          if (at_vote) begin
            if (maj) begin
              state_q <= StIdle;
              armed_q <= 1'b1;
            end else begin
              state_q <= StWaitHigh;
            end
          end
        end
        StWaitHigh: begin
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x: table of frames plus hand-written corner sequences,
// with a byte scoreboard fed at stimulus time and drained on each valid&ready handshake.
module tb_uart_rx_16x;

  localparam int unsigned CLK_FREQ  = 1228800;
  localparam int unsigned BAUD_RATE = 9600;
  localparam int BIT = 128;  // 16 ticks of 8 clocks
  localparam int GAP = 2 * BIT;

  logic       clk, rst, rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int n_vec = 0;
  int n_err = 0;
  int deliv_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
  int exp_deliv = 0, exp_ferr = 0, exp_ovr = 0;
  logic [7:0] sb[$];

  uart_rx_16x #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: drains the scoreboard on handshakes and counts error pulses.
  always @(negedge clk) begin
    if (valid && ready) begin
      deliv_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got byte %0h, expected none", data);
      end else begin
        chk("sb_data", int'(data), int'(sb.pop_front()));
      end
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int stop_len, input bit spike,
                      input bit bad_stop);
    logic [9:0] frame;
    frame = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      int len;
      len = (i == 9) ? stop_len : BIT;
      for (int j = 0; j < len; j++) begin
        rx = frame[i];
        // Flip only the middle vote sample of each data bit.
        if (spike && i >= 1 && i <= 8 && j >= 70 && j <= 76) rx = ~frame[i];
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_deliv"}, deliv_cnt, exp_deliv);
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_ovr"}, ovr_cnt, exp_ovr);
  endtask

  typedef struct {
    logic [7:0] tx;
    int         stop_len;
    bit         spike;
    bit         bad_stop;
    int         gap;
    bit         exp_byte;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h41, BIT, 1'b0, 1'b0, GAP, 1'b1, 1'b0};
    vecs[1] = '{8'h00, BIT, 1'b0, 1'b0, GAP, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, BIT, 1'b0, 1'b0, GAP, 1'b1, 1'b0};
    vecs[3] = '{8'h35, 77,  1'b0, 1'b0, 0,   1'b1, 1'b0};
    vecs[4] = '{8'h46, BIT, 1'b0, 1'b0, GAP, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, BIT, 1'b1, 1'b0, GAP, 1'b1, 1'b0};
    vecs[6] = '{8'h5A, BIT, 1'b1, 1'b0, GAP, 1'b1, 1'b0};
    vecs[7] = '{8'h55, BIT, 1'b0, 1'b1, GAP, 1'b0, 1'b1};

    rst = 1'b0;
    rx = 1'b1;
    ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    hold(1'b1, GAP);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].exp_byte) begin
        sb.push_back(vecs[v].tx);
        exp_deliv++;
      end
      if (vecs[v].exp_ferr) exp_ferr++;
      send(vecs[v].tx, vecs[v].stop_len, vecs[v].spike, vecs[v].bad_stop);
      if (vecs[v].gap > 0) begin
        hold(1'b1, vecs[v].gap);
        chk_counts($sformatf("vec%0d", v));
      end
    end

    // Short low glitch on an idle line must abort in START.
    hold(1'b0, 30);
    hold(1'b1, 3 * BIT);
    chk_counts("glitch");
    chk("glitch_valid", int'(valid), 0);

    // Bad stop bit followed by a line held low for three frames: one frame_err only.
    send(8'h55, BIT, 1'b0, 1'b1);
    hold(1'b0, 30 * BIT);
    exp_ferr++;
    hold(1'b1, GAP);
    chk_counts("break");
    sb.push_back(8'h39);
    exp_deliv++;
    send(8'h39, BIT, 1'b0, 1'b0);
    hold(1'b1, GAP);
    chk_counts("after_break");

    // Backpressure: second byte overruns, first stays held until ready.
    ready = 1'b0;
    sb.push_back(8'h31);
    exp_deliv++;
    send(8'h31, BIT, 1'b0, 1'b0);
    hold(1'b1, GAP);
    chk("hold1_valid", int'(valid), 1);
    chk("hold1_data", int'(data), 8'h31);
    send(8'h32, BIT, 1'b0, 1'b0);
    hold(1'b1, GAP);
    exp_ovr++;
    chk("hold2_valid", int'(valid), 1);
    chk("hold2_data", int'(data), 8'h31);
    chk("hold2_ovr", ovr_cnt, exp_ovr);
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", int'(valid), 0);
    chk_counts("backpressure");

    // Async reset mid-byte with a byte held in the output register.
    ready = 1'b0;
    send(8'h3A, BIT, 1'b0, 1'b0);
    hold(1'b1, GAP);
    chk("prerst_valid", int'(valid), 1);
    hold(1'b0, 3 * BIT + 64);  // start, bit0, bit1, half of bit2 of 0xF0
    rst = 1'b0;
    #1;
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_data", int'(data), 0);
    hold(1'b0, 5);
    rst = 1'b1;
    hold(1'b0, 59 + BIT);
    hold(1'b1, 5 * BIT + 3 * BIT);
    chk("postrst_valid", int'(valid), 0);
    chk_counts("postrst");
    ready = 1'b1;
    sb.push_back(8'h30);
    exp_deliv++;
    send(8'h30, BIT, 1'b0, 1'b0);
    hold(1'b1, GAP);
    chk_counts("after_rst");

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
